registrador_deslocamento_piso: RTL and testbench

//   Parallel-in/serial-out shift register: the transmit end of the serial bit link whose receive end is
//   the serial-in/parallel-out ShiftRegister (novoBit -> saidaFlipFlop1..4). Accepts a LARGURA-bit word via

---
 rtl/registrador_pkg.sv | 17 +
 rtl/contador_bits_piso.sv | 26 ++
 rtl/registrador_deslocamento_piso.sv | 129 ++++++++++++
 tb/tb_registrador_deslocamento_piso.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/registrador_pkg.sv
// Shared types and helpers for the serial bit link (PISO transmitter and the future receive side).
package registrador_pkg;

   typedef enum logic [1:0] {
      OCIOSO,
      DESLOCANDO,
      PARIDADE
   } estado_t;

   localparam int LARGURA_MAX = 32;

   // Even parity bit: makes the total count of ones (word + parity) even.
   function automatic logic paridade_par(input logic [LARGURA_MAX-1:0] palavra);
      return ^palavra;
   endfunction

endpackage

// File: rtl/contador_bits_piso.sv
// Loadable down counter that tracks the cycles remaining in a frame; saturates at zero.
module contador_bits_piso #(
   parameter int LARGURA_CONT = 3
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    carga,
   input  logic [LARGURA_CONT-1:0] valor,
   input  logic                    decrementa,
   output logic [LARGURA_CONT-1:0] contagem,
   output logic                    zero
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         contagem <= '0;
      end else if (carga) begin
         contagem <= valor;
      end else if (decrementa && !zero) begin
         contagem <= contagem - 1'b1;
      end
   end

   assign zero = (contagem == '0);

endmodule

// File: rtl/registrador_deslocamento_piso.sv
// Parallel-in/serial-out transmitter for the serial bit link.
// Define REGISTRADOR_PISO_PARIDADE_EN to append an even-parity bit to every frame.
module registrador_deslocamento_piso
   import registrador_pkg::*;
#(
   parameter int LARGURA      = 4,
   parameter bit MSB_PRIMEIRO = 1'b1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [LARGURA-1:0] dadoEntrada,
   input  logic               carregar,
   output logic               pronto,
   output logic               bitSaida,
   output logic               bitValido,
   output logic               fimQuadro
);

   localparam int LARGURA_CONT = $clog2(LARGURA + 2);
`ifdef REGISTRADOR_PISO_PARIDADE_EN
   localparam int BITS_QUADRO = LARGURA + 1;
`else
   localparam int BITS_QUADRO = LARGURA;
`endif
   // Counter holds the cycles left after the current one, so zero marks the final frame cycle.
   localparam logic [LARGURA_CONT-1:0] CARGA = LARGURA_CONT'(BITS_QUADRO - 1);
   localparam logic [LARGURA_CONT-1:0] UM    = LARGURA_CONT'(1);

   estado_t                 estado;
   logic [LARGURA-1:0]      deslocador;
   logic [LARGURA_CONT-1:0] contagem;
   logic                    contagem_zero;
   logic                    aceita;
   logic                    primeiro_bit;
   logic                    proximo_bit;
   logic [LARGURA-1:0]      entrada_deslocada;
   logic [LARGURA-1:0]      deslocador_prox;
`ifdef REGISTRADOR_PISO_PARIDADE_EN
   logic                    paridade_q;
`endif

   assign pronto = (estado == OCIOSO) || contagem_zero;
   assign aceita = carregar && pronto;

   always_comb begin
      if (MSB_PRIMEIRO) begin
         primeiro_bit      = dadoEntrada[LARGURA-1];
         entrada_deslocada = dadoEntrada << 1;
         proximo_bit       = deslocador[LARGURA-1];
         deslocador_prox   = deslocador << 1;
      end else begin
         primeiro_bit      = dadoEntrada[0];
         entrada_deslocada = dadoEntrada >> 1;
         proximo_bit       = deslocador[0];
         deslocador_prox   = deslocador >> 1;
      end
   end

   contador_bits_piso #(
      .LARGURA_CONT(LARGURA_CONT)
   ) u_contador (
      .clock     (clock),
      .reset     (reset),
      .carga     (aceita),
      .valor     (CARGA),
      .decrementa(!aceita),
      .contagem  (contagem),
      .zero      (contagem_zero)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado     <= OCIOSO;
         deslocador <= '0;
         bitSaida   <= 1'b0;
         bitValido  <= 1'b0;
         fimQuadro  <= 1'b0;
`ifdef REGISTRADOR_PISO_PARIDADE_EN
         paridade_q <= 1'b0;
`endif
      end else if (aceita) begin
         // The first bit goes out straight from the input; the shifter keeps the rest.
         estado     <= DESLOCANDO;
         deslocador <= entrada_deslocada;
         bitSaida   <= primeiro_bit;
         bitValido  <= 1'b1;
         fimQuadro  <= 1'b0;
`ifdef REGISTRADOR_PISO_PARIDADE_EN
         paridade_q <= paridade_par(LARGURA_MAX'(dadoEntrada));
`endif
      end else begin
         case (estado)
            DESLOCANDO: begin
               if (contagem_zero) begin
                  estado    <= OCIOSO;
                  bitSaida  <= 1'b0;
                  bitValido <= 1'b0;
                  fimQuadro <= 1'b0;
`ifdef REGISTRADOR_PISO_PARIDADE_EN
               end else if (contagem == UM) begin
                  estado    <= PARIDADE;
                  bitSaida  <= paridade_q;
                  bitValido <= 1'b1;
                  fimQuadro <= 1'b1;
`endif
               end else begin
                  deslocador <= deslocador_prox;
                  bitSaida   <= proximo_bit;
                  bitValido  <= 1'b1;
                  fimQuadro  <= (contagem == UM);
               end
            end
            PARIDADE: begin
               estado    <= OCIOSO;
               bitSaida  <= 1'b0;
               bitValido <= 1'b0;
               fimQuadro <= 1'b0;
            end
            default: begin
               estado    <= OCIOSO;
               bitSaida  <= 1'b0;
               bitValido <= 1'b0;
               fimQuadro <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_registrador_deslocamento_piso.sv
// Directed bench for registrador_deslocamento_piso: one MSB-first instance and one LSB-first instance.
module tb_registrador_deslocamento_piso;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] dado_a, dado_b;
   logic       carregar_a, carregar_b;
   logic       pronto_a, bit_a, valido_a, fim_a;
   logic       pronto_b, bit_b, valido_b, fim_b;
   logic [3:0] obs_a, obs_b;
   logic [3:0] rx;
   logic       rx_clr;
   logic [7:0] seq;
   int         n_checks = 0;
   int         n_fail   = 0;

   always #5 clock = ~clock;

   registrador_deslocamento_piso #(
      .LARGURA(4),
      .MSB_PRIMEIRO(1'b1)
   ) dut_a (
      .clock      (clock),
      .reset      (reset),
      .dadoEntrada(dado_a),
      .carregar   (carregar_a),
      .pronto     (pronto_a),
      .bitSaida   (bit_a),
      .bitValido  (valido_a),
      .fimQuadro  (fim_a)
   );

   registrador_deslocamento_piso #(
      .LARGURA(4),
      .MSB_PRIMEIRO(1'b0)
   ) dut_b (
      .clock      (clock),
      .reset      (reset),
      .dadoEntrada(dado_b),
      .carregar   (carregar_b),
      .pronto     (pronto_b),
      .bitSaida   (bit_b),
      .bitValido  (valido_b),
      .fimQuadro  (fim_b)
   );

   // Packed view: {bitSaida, bitValido, fimQuadro, pronto}
   assign obs_a = {bit_a, valido_a, fim_a, pronto_a};
   assign obs_b = {bit_b, valido_b, fim_b, pronto_b};

   // Receiver ShiftRegister model: novoBit -> flop1 -> ... -> flop4, rx = {flop4..flop1}.
   always @(posedge clock) begin
      if (rx_clr) rx <= 4'b0000;
      else if (valido_a) rx <= {rx[2:0], bit_a};
   end

   task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] esp);
      n_checks++;
      if (obs !== esp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, obs, esp);
      end
   endtask

   task automatic ciclo();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset      = 1'b1;
      dado_a     = 4'h0;
      dado_b     = 4'h0;
      carregar_a = 1'b0;
      carregar_b = 1'b0;
      rx_clr     = 1'b1;
      ciclo();
      ciclo();
      reset = 1'b0;
      ciclo();
      check_eq("reset_a", obs_a, 4'b0001);
      check_eq("reset_b", obs_b, 4'b0001);

      // 1: single frame 1011, MSB first
      dado_a     = 4'b1011;
      carregar_a = 1'b1;
      seq        = 8'b0000_1011;
      for (int k = 1; k <= 4; k++) begin
         ciclo();
         carregar_a = 1'b0;
         check_eq($sformatf("t1_c%0d", k), obs_a, {seq[4-k], 1'b1, k == 4, k == 4});
      end
      ciclo();
      check_eq("t1_idle", obs_a, 4'b0001);

      // 2: loopback into receiver
      rx_clr = 1'b1;
      ciclo();
      rx_clr     = 1'b0;
      dado_a     = 4'b1000;
      carregar_a = 1'b1;
      ciclo();
      carregar_a = 1'b0;
      for (int k = 0; k < 4; k++) ciclo();
      check_eq("t2_rx", rx, 4'b1000);
      check_eq("t2_idle", obs_a, 4'b0001);

      // 3: back-to-back A then 5 with carregar held
      dado_a     = 4'hA;
      carregar_a = 1'b1;
      seq        = 8'b1010_0101;
      for (int k = 1; k <= 8; k++) begin
         ciclo();
         check_eq($sformatf("t3_c%0d", k), obs_a,
                  {seq[8-k], 1'b1, (k == 4) || (k == 8), (k == 4) || (k == 8)});
         if (k == 4) dado_a = 4'h5;
         if (k == 5) carregar_a = 1'b0;
      end
      ciclo();
      check_eq("t3_idle", obs_a, 4'b0001);

      // 4: carregar while busy is ignored
      dado_a     = 4'h3;
      carregar_a = 1'b1;
      seq        = 8'b0000_0011;
      for (int k = 1; k <= 4; k++) begin
         ciclo();
         check_eq($sformatf("t4_c%0d", k), obs_a, {seq[4-k], 1'b1, k == 4, k == 4});
         if (k == 1) carregar_a = 1'b0;
         if (k == 2) begin
            carregar_a = 1'b1;
            dado_a     = 4'hF;
         end
         if (k == 3) carregar_a = 1'b0;
      end
      ciclo();
      check_eq("t4_idle", obs_a, 4'b0001);

      // 5: asynchronous reset mid-frame
      dado_a     = 4'hC;
      carregar_a = 1'b1;
      ciclo();
      carregar_a = 1'b0;
      ciclo();
      check_eq("t5_c2", obs_a, 4'b1100);
      #2 reset = 1'b1;
      #1 check_eq("t5_abort", obs_a, 4'b0001);
      #3 reset = 1'b0;
      ciclo();
      check_eq("t5_post1", obs_a, 4'b0001);
      ciclo();
      check_eq("t5_post2", obs_a, 4'b0001);
      dado_a     = 4'h6;
      carregar_a = 1'b1;
      seq        = 8'b0000_0110;
      for (int k = 1; k <= 4; k++) begin
         ciclo();
         carregar_a = 1'b0;
         check_eq($sformatf("t5_f%0d", k), obs_a, {seq[4-k], 1'b1, k == 4, k == 4});
      end

      // 6: LSB first on dut_b, 1011 -> 1,1,0,1 (+ parity 1 when enabled)
      dado_b     = 4'b1011;
      carregar_b = 1'b1;
      seq        = 8'b0000_1101;
      for (int k = 1; k <= 4; k++) begin
         ciclo();
         carregar_b = 1'b0;
`ifdef REGISTRADOR_PISO_PARIDADE_EN
         check_eq($sformatf("t6_c%0d", k), obs_b, {seq[4-k], 1'b1, 1'b0, 1'b0});
`else
         check_eq($sformatf("t6_c%0d", k), obs_b, {seq[4-k], 1'b1, k == 4, k == 4});
`endif
      end
`ifdef REGISTRADOR_PISO_PARIDADE_EN
      ciclo();
      check_eq("t6_par", obs_b, 4'b1111);
`endif
      ciclo();
      check_eq("t6_idle", obs_b, 4'b0001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
